// File: rtl/pipe_shifter_if.sv
// pipe_shifter_if: valid/ready operation and result bundle for pipe_shifter
interface pipe_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  localparam int SHW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic [2:0]       mode;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out8;
  logic [TAGW-1:0]  out_tag;
  modport master (
    output in_valid, a, shamt, mode, in_tag, out_ready,
    input  in_ready, out_valid, out8, out_tag
  );
  modport slave (
    input  in_valid, a, shamt, mode, in_tag, out_ready,
    output in_ready, out_valid, out8, out_tag
  );
endinterface

// File: rtl/pipe_shifter.sv
// pipe_shifter: log2(WIDTH)-stage pipelined shifter/rotator, largest step first, whole-pipe stall on output backpressure
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input logic           clk,
  input logic           rst_n,
  pipe_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  for (genvar k = 0; k < SHW; k++) begin : g_st
    localparam int S = 1 << (SHW - 1 - k);
    logic             v, vq;
    logic [WIDTH-1:0] d, r, dq;
    logic [SHW-1:0]   s, sq;
    logic [2:0]       m, mq;
    logic [TAGW-1:0]  t, tq;
    if (k == 0) begin : g_src
      assign v = bus.in_valid;
      assign d = bus.a;
      assign s = bus.shamt;
      assign m = bus.mode;
      assign t = bus.in_tag;
    end else begin : g_src
      assign v = g_st[k-1].vq;
      assign d = g_st[k-1].dq;
      assign s = g_st[k-1].sq;
      assign m = g_st[k-1].mq;
      assign t = g_st[k-1].tq;
    end
    always_comb
      r = !s[SHW-1-k] ? d :
          m == 3'd0   ? {d[WIDTH-1-S:0], {S{1'b0}}} :
          m == 3'd1   ? {{S{1'b0}}, d[WIDTH-1:S]} :
          m == 3'd2   ? {{S{d[WIDTH-1]}}, d[WIDTH-1:S]} :
          m == 3'd3   ? {d[S-1:0], d[WIDTH-1:S]} :
          m == 3'd4   ? {d[WIDTH-1-S:0], d[WIDTH-1:WIDTH-S]} : d;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vq <= 1'b0;
        dq <= '0;
        sq <= '0;
        mq <= '0;
        tq <= '0;
      end else if (!stall) begin
        vq <= v;
        dq <= r;
        sq <= s;
        mq <= m;
        tq <= t;
      end
  end
  assign bus.out_valid = g_st[SHW-1].vq;
  assign bus.out8      = g_st[SHW-1].dq;
  assign bus.out_tag   = g_st[SHW-1].tq;
endmodule
